// File: rtl/mac_tx_if.sv
// mac_tx_if: upstream handshake/stream and GMII transmit signals of the MAC TX stage
interface mac_tx_if;
    logic       mac_tx_req;
    logic       mac_tx_ack;
    logic       mac_tx_ready;
    logic       mac_data_req;
    logic [7:0] mac_tx_data;
    logic       mac_tx_end;
    logic       mac_send_end;
    logic       mac_tx_busy;
    logic       mac_tx_err;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    modport master (
        output mac_tx_req, mac_tx_ready, mac_tx_data, mac_tx_end,
        input  mac_tx_ack, mac_data_req, mac_send_end, mac_tx_busy, mac_tx_err, gmii_tx_en, gmii_txd
    );
    modport slave (
        input  mac_tx_req, mac_tx_ready, mac_tx_data, mac_tx_end,
        output mac_tx_ack, mac_data_req, mac_send_end, mac_tx_busy, mac_tx_err, gmii_tx_en, gmii_txd
    );
endinterface

// File: rtl/mac_tx.sv
// mac_tx: Ethernet MAC TX stage (preamble/SFD, CRC-32 FCS, IFG); define MAC_TX_PAD_EN to zero-pad frames to 60 bytes
module mac_tx #(
    parameter int REQ_LAT       = 2,
    parameter int IFG_CYCLES    = 12,
    parameter int READY_TIMEOUT = 65535,
    parameter int MAX_LEN       = 1514
) (
    input logic     clk,
    input logic     rst,
    mac_tx_if.slave io_mac
);
    typedef enum logic [3:0] {
        S_IDLE, S_ACK, S_WAIT, S_PRE, S_DATA, S_FCS, S_IFG, S_END
`ifdef MAC_TX_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_len;
    logic [31:0] r_crc;
    logic        r_ack;
    logic        r_data_req;
    logic        r_send_end;
    logic        r_err;
    logic        r_tx_en;
    logic [7:0]  r_txd;
    logic        w_sample;
    logic [15:0] w_len_nx;
    logic [31:0] w_fcs;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign w_sample = (r_state == S_DATA) || (r_state == S_PRE && r_cnt == 16'd7);
    assign w_len_nx = r_len + 16'd1;
    assign w_fcs    = ~r_crc;
`ifdef MAC_TX_PAD_EN
    logic w_short;
    assign w_short  = w_len_nx < 16'd60;
`endif

    assign io_mac.mac_tx_ack   = r_ack;
    assign io_mac.mac_data_req = r_data_req;
    assign io_mac.mac_send_end = r_send_end;
    assign io_mac.mac_tx_err   = r_err;
    assign io_mac.mac_tx_busy  = r_state != S_IDLE;
    assign io_mac.gmii_tx_en   = r_tx_en;
    assign io_mac.gmii_txd     = r_txd;

    // Frame sequencer; every output is registered and shows the byte chosen on the previous edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_crc      <= '1;
            r_ack      <= 1'b0;
            r_data_req <= 1'b0;
            r_send_end <= 1'b0;
            r_err      <= 1'b0;
            r_tx_en    <= 1'b0;
            r_txd      <= '0;
        end else begin
            r_ack      <= 1'b0;
            r_data_req <= 1'b0;
            r_send_end <= 1'b0;
            r_err      <= 1'b0;
            if (w_sample) begin
                r_txd <= io_mac.mac_tx_data;
                r_crc <= crc_byte(r_crc, io_mac.mac_tx_data);
                r_len <= w_len_nx;
                r_cnt <= '0;
                if (io_mac.mac_tx_end) begin
`ifdef MAC_TX_PAD_EN
                    r_state <= w_short ? S_PAD : S_FCS;
`else
                    r_state <= S_FCS;
`endif
                end else if (w_len_nx == 16'(MAX_LEN)) begin
                    r_state <= S_FCS;
                    r_err   <= 1'b1;
                end else begin
                    r_state <= S_DATA;
                end
            end else begin
                case (r_state)
                    S_IDLE: if (io_mac.mac_tx_req) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                    S_ACK: begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end
                    S_WAIT: if (io_mac.mac_tx_ready) begin
                        r_state    <= S_PRE;
                        r_cnt      <= '0;
                        r_tx_en    <= 1'b1;
                        r_txd      <= 8'h55;
                        r_data_req <= REQ_LAT == 7;
                    end else if (r_cnt + 16'd1 == 16'(READY_TIMEOUT)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    S_PRE: begin
                        r_cnt      <= r_cnt + 16'd1;
                        r_txd      <= r_cnt == 16'd6 ? 8'hD5 : 8'h55;
                        r_data_req <= r_cnt == 16'(6 - REQ_LAT);
                    end
`ifdef MAC_TX_PAD_EN
                    S_PAD: begin
                        r_txd <= 8'h00;
                        r_crc <= crc_byte(r_crc, 8'h00);
                        r_len <= w_len_nx;
                        if (w_len_nx == 16'd60) r_state <= S_FCS;
                    end
`endif
                    S_FCS: begin
                        r_txd <= 8'(w_fcs >> {r_cnt[1:0], 3'b000});
                        r_cnt <= r_cnt == 16'd3 ? 16'd0 : r_cnt + 16'd1;
                        if (r_cnt == 16'd3) r_state <= S_IFG;
                    end
                    S_IFG: begin
                        r_tx_en <= 1'b0;
                        r_txd   <= 8'h00;
                        r_cnt   <= r_cnt + 16'd1;
                        if (r_cnt == 16'(IFG_CYCLES)) begin
                            r_state    <= S_END;
                            r_send_end <= 1'b1;
                        end
                    end
                    S_END: begin
                        r_state <= S_IDLE;
                        r_crc   <= '1;
                        r_len   <= '0;
                        r_cnt   <= '0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: scoreboard bench for mac_tx (frames, handshake, truncation, timeout, async reset)
module tb_mac_tx;
    localparam int MAXL = 64;
`ifdef MAC_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_tx_if bus();
    mac_tx #(.MAX_LEN(MAXL)) dut (.clk(clk), .rst(rst), .io_mac(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0, ack_cyc = 0, err_cnt = 0, end_cnt = 0, end_cyc = 0;
    int dreq_cyc = 0, fall_cyc = 0, en_len = 0, en_total = 0, exp_en_len = 0;
    logic prev_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [7:0] frame[$];
    logic [7:0] up[$];
    logic up_end = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] m[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (m[k])
            for (int b = 0; b < 8; b++) c = (c >> 1) ^ ((c[0] ^ m[k][b]) ? 32'hEDB88320 : 32'h0);
        return ~c;
    endfunction

    task automatic prep(input logic use_end, input logic [31:0] lit);
        logic [7:0] sent[$];
        logic [31:0] f;
        up = frame;
        up_end = use_end;
        for (int i = 0; i < frame.size() && i < MAXL; i++) sent.push_back(frame[i]);
        if (PAD && use_end) while (sent.size() < 60) sent.push_back(8'h00);
        f = (lit != 0) ? lit : ref_crc(sent);
        repeat (7) exp_q.push_back(32'h55);
        exp_q.push_back(32'hD5);
        foreach (sent[i]) exp_q.push_back({24'h0, sent[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({24'h0, f[8*i +: 8]});
        exp_en_len = 12 + sent.size();
    endtask

    task automatic request();
        repeat (24) @(posedge clk);
        #1;
        chk("ack_idle", {31'h0, bus.mac_tx_ack}, 0);
        bus.mac_tx_req = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_lat", {31'h0, bus.mac_tx_ack}, 1);
    endtask

    task automatic wait_end(input int lim);
        int n;
        int k;
        n = end_cnt;
        k = 0;
        while (end_cnt == n && k < lim) begin
            @(posedge clk);
            k++;
        end
        chk("send_end", end_cnt - n, 1);
    endtask

    // Upstream model: streams the prepared frame REQ_LAT cycles after mac_data_req
    initial begin
        logic [7:0] cur[$];
        logic ce;
        bus.mac_tx_data = 8'h00;
        bus.mac_tx_end = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mac_data_req) begin
                cur = up;
                ce = up_end;
                repeat (2) @(posedge clk);
                #1;
                foreach (cur[i]) begin
                    bus.mac_tx_data = cur[i];
                    bus.mac_tx_end = ce && (i == cur.size() - 1);
                    @(posedge clk);
                    #1;
                end
                bus.mac_tx_data = 8'h00;
                bus.mac_tx_end = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every tx_en cycle and checks frame timing
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mac_data_req) dreq_cyc = cyc;
                if (bus.mac_tx_ack) begin
                    ack_cnt++;
                    ack_cyc = cyc;
                end
                if (bus.mac_tx_err) err_cnt++;
                if (bus.gmii_tx_en) begin
                    if (en_len == 7) chk("dreq_lead", cyc - dreq_cyc, 2);
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    else e = 32'h100;
                    chk("txd", {24'h0, bus.gmii_txd}, e);
                    en_len++;
                    en_total++;
                end
                if (prev_en && !bus.gmii_tx_en) fall_cyc = cyc;
                prev_en = bus.gmii_tx_en;
                if (bus.mac_send_end) begin
                    end_cnt++;
                    end_cyc = cyc;
                    chk("ifg", cyc - fall_cyc, 12);
                    chk("en_len", en_len, exp_en_len);
                    chk("q_left", exp_q.size(), 0);
                    en_len = 0;
                end
            end
        end
    end

    initial begin
        int a0, e0, n, k, et;
        bus.mac_tx_req = 1'b0;
        bus.mac_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'h0, bus.mac_tx_ack}, 0);
        chk("rst_busy", {31'h0, bus.mac_tx_busy}, 0);
        chk("rst_dreq", {31'h0, bus.mac_data_req}, 0);
        chk("rst_end", {31'h0, bus.mac_send_end}, 0);
        chk("rst_err", {31'h0, bus.mac_tx_err}, 0);
        chk("rst_en", {31'h0, bus.gmii_tx_en}, 0);
        chk("rst_txd", {24'h0, bus.gmii_txd}, 0);
        @(negedge clk);
        rst = 1'b0;

        frame = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        prep(1'b1, PAD ? 32'h0 : 32'hCBF43926);
        request();
        bus.mac_tx_req = 1'b0;
        wait_end(300);

        frame.delete();
        for (int i = 0; i < 42; i++) frame.push_back(8'(i * 7 + 3));
        prep(1'b1, 32'h0);
        request();
        bus.mac_tx_req = 1'b0;
        wait_end(300);

        frame.delete();
        for (int i = 0; i < 20; i++) frame.push_back(8'(i + 160));
        a0 = ack_cnt;
        prep(1'b1, 32'h0);
        request();
        wait_end(300);
        chk("held_acks", ack_cnt - a0, 1);
        frame.delete();
        for (int i = 0; i < 10; i++) frame.push_back(8'(255 - i));
        prep(1'b1, 32'h0);
        k = 0;
        while (ack_cnt - a0 < 2 && k < 20) begin
            @(posedge clk);
            k++;
        end
        chk("regrant", ack_cyc - end_cyc, 2);
        bus.mac_tx_req = 1'b0;
        wait_end(300);

        frame.delete();
        for (int i = 0; i < 100; i++) frame.push_back(8'(i) ^ 8'h5A);
        e0 = err_cnt;
        prep(1'b0, 32'h0);
        request();
        bus.mac_tx_req = 1'b0;
        wait_end(400);
        chk("trunc_err", err_cnt - e0, 1);

        frame.delete();
        for (int i = 0; i < 30; i++) frame.push_back(8'(i * 3));
        prep(1'b1, 32'h0);
        request();
        bus.mac_tx_req = 1'b0;
        k = 0;
        while (en_len < 20 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #3;
        chk("pre_rst_en", {31'h0, bus.gmii_tx_en}, 1);
        n = end_cnt;
        rst = 1'b1;
        #1;
        chk("arst_en", {31'h0, bus.gmii_tx_en}, 0);
        chk("arst_txd", {24'h0, bus.gmii_txd}, 0);
        chk("arst_busy", {31'h0, bus.mac_tx_busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        en_len = 0;
        prev_en = 1'b0;
        repeat (40) @(posedge clk);
        chk("arst_no_end", end_cnt - n, 0);
        frame = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        prep(1'b1, PAD ? 32'h0 : 32'hCBF43926);
        request();
        bus.mac_tx_req = 1'b0;
        wait_end(300);

        bus.mac_tx_ready = 1'b0;
        et = en_total;
        n = end_cnt;
        e0 = err_cnt;
        request();
        bus.mac_tx_req = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (bus.mac_tx_busy && k < 70000);
        chk("to_cycles", cyc - ack_cyc, 65536);
        chk("to_no_en", en_total - et, 0);
        chk("to_no_end", end_cnt - n, 0);
        chk("to_no_err", err_cnt - e0, 0);
        bus.mac_tx_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
